// File: rtl/dds_phase_gen.sv
// DDS phase generator: FTW register with button stepping, phase accumulator, ROM address.
// Define DDS_DEBOUNCE_EN to build the button debounce counters.
module dds_phase_gen #(
  parameter int          ACC_W       = 32,
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] FTW_DEFAULT = 32'h0100_0000,
  parameter logic [31:0] FTW_STEP    = 32'h0010_0000,
  parameter logic [31:0] FTW_MIN     = 32'h0010_0000,
  parameter logic [31:0] FTW_MAX     = 32'h4000_0000,
  parameter logic [19:0] DEB_CYCLES  = 20'd1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              phase_clr,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              ftw_load,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic [ADDR_W-1:0] phase_off,
  output logic [ADDR_W-1:0] address,
  output logic [ACC_W-1:0]  ftw_out,
  output logic              wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw;
  logic [ACC_W-1:0] ftw_nxt;
  logic [1:0]       up_sync;
  logic [1:0]       dn_sync;
  logic             up_lvl, dn_lvl;
  logic             up_lvl_d, dn_lvl_d;
  logic             up_p, dn_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_down};
    end
  end

`ifdef DDS_DEBOUNCE_EN
  logic [19:0] up_cnt, dn_cnt;
  logic        up_deb, dn_deb;

  // A level is accepted only after it differs from the debounced level for DEB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt <= '0;
      dn_cnt <= '0;
      up_deb <= 1'b0;
      dn_deb <= 1'b0;
    end else begin
      if (up_sync[1] == up_deb) begin
        up_cnt <= '0;
      end else if (up_cnt == DEB_CYCLES - 20'd1) begin
        up_deb <= up_sync[1];
        up_cnt <= '0;
      end else begin
        up_cnt <= up_cnt + 20'd1;
      end
      if (dn_sync[1] == dn_deb) begin
        dn_cnt <= '0;
      end else if (dn_cnt == DEB_CYCLES - 20'd1) begin
        dn_deb <= dn_sync[1];
        dn_cnt <= '0;
      end else begin
        dn_cnt <= dn_cnt + 20'd1;
      end
    end
  end

  assign up_lvl = up_deb;
  assign dn_lvl = dn_deb;
`else
  logic deb_cycles_unused;
  assign deb_cycles_unused = ^DEB_CYCLES;
  assign up_lvl = up_sync[1];
  assign dn_lvl = dn_sync[1];
`endif

  // Step pulses fire on press only; release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_lvl_d <= 1'b0;
      dn_lvl_d <= 1'b0;
      up_p     <= 1'b0;
      dn_p     <= 1'b0;
    end else begin
      up_lvl_d <= up_lvl;
      dn_lvl_d <= dn_lvl;
      up_p     <= up_lvl & ~up_lvl_d;
      dn_p     <= dn_lvl & ~dn_lvl_d;
    end
  end

  logic [ACC_W:0]        up_sum;
  logic signed [ACC_W:0] dn_dif;

  // One extra bit keeps the saturating step free of wrap and underflow.
  always_comb begin
    up_sum  = {1'b0, ftw} + {1'b0, FTW_STEP[ACC_W-1:0]};
    dn_dif  = $signed({1'b0, ftw}) - $signed({1'b0, FTW_STEP[ACC_W-1:0]});
    ftw_nxt = ftw;
    if (ftw_load) begin
      ftw_nxt = ftw_in;
    end else if (up_p && dn_p) begin
      ftw_nxt = ftw;
    end else if (up_p) begin
      if (up_sum > {1'b0, FTW_MAX[ACC_W-1:0]}) ftw_nxt = FTW_MAX[ACC_W-1:0];
      else                                     ftw_nxt = up_sum[ACC_W-1:0];
    end else if (dn_p) begin
      if (dn_dif < $signed({1'b0, FTW_MIN[ACC_W-1:0]})) ftw_nxt = FTW_MIN[ACC_W-1:0];
      else                                               ftw_nxt = dn_dif[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ftw <= FTW_DEFAULT[ACC_W-1:0];
    else     ftw <= ftw_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (phase_clr) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      {wrap, acc} <= {1'b0, acc} + {1'b0, ftw};
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) address <= '0;
    else     address <= acc[ACC_W-1 -: ADDR_W] + phase_off;
  end

  assign ftw_out = ftw;

endmodule
